crc_serial_chk: RTL and testbench
=================================

# crc_serial_chk

Parametrised serial CRC frame checker, the successor to the fixed 8-bit serial CRC engine. It accepts one bit per valid cycle and runs a generic MSB-feedback LFSR over a fixed-length payload. It then captures the transmitted CRC field that follows and reports pass/fail, or an inter-bit timeout, with a one-cycle done pulse. It sits behind the serial link deserialiser and qualifies each received frame before register-file update.

## Interface
- CRC_W, 8, CRC width in bits (4..32)
- POLY, 8'h2F, polynomial without implicit top term (x^8+x^5+x^3+x^2+x+1)
- INIT, all ones, LFSR value loaded at frame start
- XOR_OUT, 0, value XORed into the LFSR before comparison
- DATA_BITS, 16, payload bits per frame (>=1)
- TMO_CYC, 64, max idle cycles between valid bits inside a frame (>=1)
- CNT_W, 5, bit-counter width; must hold DATA_BITS+CRC_W-1
- TMO_W, 7, timeout-counter width; must hold TMO_CYC

Ports:
- i_clk  in  1  single clock, all logic rising-edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_vld  in  1  i_data/i_sof qualify this cycle
- i_data  in  1  serial bit, frame order (payload then CRC, CRC MSB first)
- i_sof  in  1  with i_vld: this bit is the first payload bit of a new frame
- o_busy  out  1  frame in progress (DATA or CRC state)
- o_crc  out  CRC_W  running LFSR value (raw, before XOR_OUT)
- o_done  out  1  one-cycle pulse: frame finished or timed out
- o_pass  out  1  last frame CRC matched; held until next o_done
- o_tmo  out  1  last frame ended by timeout; held until next o_done

## Operation
- LFSR step per accepted payload bit: fb = crc[CRC_W-1] ^ d; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
- States: IDLE, DATA, CRC.
- IDLE: i_vld & ~i_sof ignored. i_vld & i_sof: LFSR = step(INIT, i_data), bit_cnt = 1, enter DATA (or CRC if DATA_BITS==1).
- DATA: each i_vld steps the LFSR and increments bit_cnt. The bit making bit_cnt == DATA_BITS moves to CRC.
- CRC: each i_vld shifts i_data into rx_crc (MSB first); LFSR is frozen. On the CRC_W-th bit, compare {rx_crc[CRC_W-2:0], i_data} == LFSR ^ XOR_OUT, then return to IDLE.
- i_sof with i_vld in DATA or CRC: current frame is discarded silently (no o_done), and the bit starts a new frame exactly as from IDLE.
- Timeout: tmo_cnt clears on every i_vld and increments on each cycle without i_vld in DATA/CRC. When it reaches TMO_CYC: go to IDLE, o_done pulse, o_pass=0, o_tmo=1.
- o_crc holds its value in IDLE, so software can read the last payload CRC.

## Timing
- Reset values: state IDLE, o_crc=INIT, o_busy=0, o_done=0, o_pass=0, o_tmo=0, counters 0, rx_crc 0.
- o_busy is 1 from the cycle after the SOF bit until the cycle after the last CRC bit or the timeout.
- Last CRC bit accepted at edge N: o_done=1 during cycle N+1 only, with o_pass valid and o_tmo=0 in the same cycle.
- Timeout: o_done asserts TMO_CYC+1 cycles after the last accepted bit.
- A new SOF may arrive in the cycle immediately after the last CRC bit (back-to-back frames, no gap required). It is accepted while o_done for the previous frame is high.
- i_vld is sampled every cycle with no backpressure; no bit is ever dropped outside IDLE.
- Reset mid-frame: returns to reset values immediately, no o_done.

## Test plan
- Defaults with DATA_BITS=8: SOF + payload 0x00 then CRC 0x42 -> o_done one cycle after the last bit, o_pass=1, o_tmo=0, o_crc=0x42.
- Same payload, CRC 0x43 -> o_done=1, o_pass=0; o_pass stays 0 until the next frame.
- Payload 0x00, then 3 CRC bits, then i_vld low for 64 cycles -> o_done on cycle 65 after the last bit, o_tmo=1, o_pass=0, o_busy=0.
- SOF asserted at payload bit 5, followed by a full good frame -> exactly one o_done, o_pass=1.
- Two good frames back-to-back with no idle cycle -> two o_done pulses exactly 16 cycles apart, both o_pass=1.
- i_rst_n low mid-CRC-field -> all outputs at reset values; a following good frame passes.

Source files
------------

// File: rtl/crc_serial_chk.sv
// ---------------------------------------------------------------------------
// crc_serial_chk
//
// Serial CRC frame checker. Accepts one bit per valid cycle, runs an
// MSB-feedback LFSR over a fixed-length payload, then captures the
// transmitted CRC field (MSB first) and reports pass/fail or an inter-bit
// timeout with a one-cycle done pulse.
//
// Ports:
//   i_clk    - clock, all logic on the rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_vld    - i_data / i_sof qualify this cycle
//   i_data   - serial bit (payload first, then CRC MSB first)
//   i_sof    - with i_vld: first payload bit of a new frame
//   o_busy   - frame in progress (DATA or CRC state)
//   o_crc    - running LFSR value (raw, before XOR_OUT); held in IDLE
//   o_done   - one-cycle pulse: frame finished or timed out
//   o_pass   - last frame CRC matched; held until next o_done
//   o_tmo    - last frame ended by timeout; held until next o_done
// ---------------------------------------------------------------------------
module crc_serial_chk #(
  parameter int unsigned      CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY      = 'h2F,
  parameter logic [CRC_W-1:0] INIT      = '1,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter int unsigned      DATA_BITS = 16,
  parameter int unsigned      TMO_CYC   = 64,
  parameter int unsigned      CNT_W     = 5,
  parameter int unsigned      TMO_W     = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic             i_data,
  input  logic             i_sof,
  output logic             o_busy,
  output logic [CRC_W-1:0] o_crc,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_tmo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2
  } state_t;

  // bit_cnt keeps counting through the CRC field, so the last payload bit and
  // the last CRC bit are both identified by a single counter compare.
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC_CNT  = CNT_W'(DATA_BITS + CRC_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TMO_CYC - 1);
  localparam bit               ONE_BIT_FRAME = (DATA_BITS == 1);

  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] c,
                                                 input logic             d);
    logic fb;
    fb = c[CRC_W-1] ^ d;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  state_t           r_state;
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] r_rx_crc;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_done;
  logic             r_pass;
  logic             r_tmo;

  logic [CRC_W-1:0] w_crc_init;
  logic [CRC_W-1:0] w_crc_step;
  logic [CRC_W-1:0] w_rx_shift;
  logic             w_crc_match;

  always_comb begin
    w_crc_init  = lfsr_step(INIT, i_data);
    w_crc_step  = lfsr_step(r_crc, i_data);
    w_rx_shift  = {r_rx_crc[CRC_W-2:0], i_data};
    w_crc_match = (w_rx_shift == (r_crc ^ XOR_OUT));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_crc     <= INIT;
      r_rx_crc  <= '0;
      r_cnt     <= '0;
      r_tmo_cnt <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_vld && i_sof) begin
        // SOF restarts from any state; an interrupted frame is dropped
        // without a done pulse and the previous pass/tmo result is kept.
        r_crc     <= w_crc_init;
        r_cnt     <= CNT_W'(1);
        r_tmo_cnt <= '0;
        r_state   <= ONE_BIT_FRAME ? S_CRC : S_DATA;
      end else if ((r_state != S_IDLE) && !i_vld) begin
        // Fires on the TMO_CYC-th idle cycle so done appears TMO_CYC+1
        // cycles after the last accepted bit.
        if (r_tmo_cnt == TMO_LAST) begin
          r_state   <= S_IDLE;
          r_tmo_cnt <= '0;
          r_cnt     <= '0;
          r_done    <= 1'b1;
          r_pass    <= 1'b0;
          r_tmo     <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
      end else if (i_vld) begin
        case (r_state)
          S_IDLE: begin
            // Bits without SOF are ignored while idle.
          end
          S_DATA: begin
            r_crc     <= w_crc_step;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_tmo_cnt <= '0;
            if (r_cnt == LAST_DATA_CNT) begin
              r_state <= S_CRC;
            end
          end
          S_CRC: begin
            r_rx_crc  <= w_rx_shift;
            r_tmo_cnt <= '0;
            if (r_cnt == LAST_CRC_CNT) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_pass  <= w_crc_match;
              r_tmo   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_crc  = r_crc;
  assign o_done = r_done;
  assign o_pass = r_pass;
  assign o_tmo  = r_tmo;

endmodule

// File: tb/tb_crc_serial_chk.sv
module tb_crc_serial_chk;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_vld;
  logic       i_data;
  logic       i_sof;
  logic       o_busy;
  logic [7:0] o_crc;
  logic       o_done;
  logic       o_pass;
  logic       o_tmo;

  int compared   = 0;
  int mismatched = 0;

  int cyc      = 0;
  int n_done   = 0;
  int last_cyc = 0;
  int prev_cyc = 0;

  crc_serial_chk #(
    .CRC_W    (8),
    .POLY     (8'h2F),
    .INIT     (8'hFF),
    .XOR_OUT  (8'h00),
    .DATA_BITS(8),
    .TMO_CYC  (64),
    .CNT_W    (5),
    .TMO_W    (7)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_vld  (i_vld),
    .i_data (i_data),
    .i_sof  (i_sof),
    .o_busy (o_busy),
    .o_crc  (o_crc),
    .o_done (o_done),
    .o_pass (o_pass),
    .o_tmo  (o_tmo)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_done) begin
      n_done   <= n_done + 1;
      prev_cyc <= last_cyc;
      last_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs held across one rising edge; returns 1ns after that edge.
  task automatic drive(input logic v, input logic s, input logic d);
    i_vld  = v;
    i_sof  = s;
    i_data = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof_first);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, sof_first && (i == 7), b[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  int n0;
  int early_done;

  initial begin
    i_rst_n = 1'b0;
    i_vld   = 1'b0;
    i_sof   = 1'b0;
    i_data  = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("rst_crc",  32'(o_crc), 32'h0FF);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_pass", 32'(o_pass), 32'h0);
    check("rst_tmo",  32'(o_tmo), 32'h0);
    i_rst_n = 1'b1;
    idle(2);

    // Bits without SOF while idle are ignored
    drive(1'b1, 1'b0, 1'b1);
    check("idle_ign_busy", 32'(o_busy), 32'h0);
    check("idle_ign_crc",  32'(o_crc), 32'h0FF);

    // Good frame: payload 0x00, CRC 0x42
    drive(1'b1, 1'b1, 1'b0);
    check("sof_crc",  32'(o_crc), 32'h0D1);
    check("sof_busy", 32'(o_busy), 32'h1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0);
    check("pay_crc",  32'(o_crc), 32'h042);
    check("pay_busy", 32'(o_busy), 32'h1);
    send_byte(8'h42, 1'b0);
    check("good_done", 32'(o_done), 32'h1);
    check("good_pass", 32'(o_pass), 32'h1);
    check("good_tmo",  32'(o_tmo), 32'h0);
    check("good_busy", 32'(o_busy), 32'h0);
    check("good_crc",  32'(o_crc), 32'h042);
    idle(1);
    check("good_done_pulse", 32'(o_done), 32'h0);
    check("good_pass_hold",  32'(o_pass), 32'h1);

    // Timeout: payload 0x00, 3 CRC bits, then silence
    send_byte(8'h00, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    early_done = 0;
    for (int k = 1; k < 64; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (o_done) early_done++;
    end
    check("tmo_early_done", 32'(early_done), 32'h0);
    check("tmo_busy_before", 32'(o_busy), 32'h1);
    drive(1'b0, 1'b0, 1'b0);
    check("tmo_done", 32'(o_done), 32'h1);
    check("tmo_flag", 32'(o_tmo), 32'h1);
    check("tmo_pass", 32'(o_pass), 32'h0);
    check("tmo_busy", 32'(o_busy), 32'h0);
    check("tmo_crc",  32'(o_crc), 32'h042);
    idle(1);
    check("tmo_done_pulse", 32'(o_done), 32'h0);

    // Bad CRC: payload 0x00, CRC 0x43
    send_byte(8'h00, 1'b1);
    send_byte(8'h43, 1'b0);
    check("bad_done", 32'(o_done), 32'h1);
    check("bad_pass", 32'(o_pass), 32'h0);
    check("bad_tmo",  32'(o_tmo), 32'h0);
    idle(5);
    check("bad_pass_hold", 32'(o_pass), 32'h0);
    check("bad_done_pulse", 32'(o_done), 32'h0);

    // SOF at payload bit 5 restarts; only the second frame completes
    n0 = n_done;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h42, 1'b0);
    check("restart_pass", 32'(o_pass), 32'h1);
    idle(2);
    check("restart_ndone", 32'(n_done - n0), 32'h1);

    // Back-to-back good frames
    n0 = n_done;
    send_byte(8'h00, 1'b1);
    send_byte(8'h42, 1'b0);
    check("b2b1_done", 32'(o_done), 32'h1);
    check("b2b1_pass", 32'(o_pass), 32'h1);
    send_byte(8'h00, 1'b1);
    check("b2b2_busy", 32'(o_busy), 32'h1);
    send_byte(8'h42, 1'b0);
    check("b2b2_done", 32'(o_done), 32'h1);
    check("b2b2_pass", 32'(o_pass), 32'h1);
    idle(1);
    check("b2b_ndone", 32'(n_done - n0), 32'h2);
    check("b2b_gap",   32'(last_cyc - prev_cyc), 32'd16);

    // Reset mid-CRC field
    n0 = n_done;
    send_byte(8'h00, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mrst_crc",  32'(o_crc), 32'h0FF);
    check("mrst_busy", 32'(o_busy), 32'h0);
    check("mrst_done", 32'(o_done), 32'h0);
    check("mrst_pass", 32'(o_pass), 32'h0);
    check("mrst_tmo",  32'(o_tmo), 32'h0);
    idle(2);
    i_rst_n = 1'b1;
    idle(1);
    check("mrst_ndone", 32'(n_done - n0), 32'h0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h42, 1'b0);
    check("post_rst_done", 32'(o_done), 32'h1);
    check("post_rst_pass", 32'(o_pass), 32'h1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
